// File: rtl/seg7_scan_driver_pkg.sv
// Purpose : shared constants, frame type and helpers for the seven-segment display blocks.
// Latency : n/a (package only).
// Backpressure: n/a.
// Ports   : none. Glyphs are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_MINUS  = 4'd10;
    localparam logic [3:0] CODE_BLANK  = 4'd15;

    localparam logic [3:0] ANODES_OFF  = 4'b1111;

    // Four digit codes (element 3 = leftmost) plus the per-digit dp mask.
    typedef struct packed {
        logic [3:0][3:0] dig;
        logic [3:0]      dpm;
    } frame_t;

    // A digit that renders as nothing or as zero can be swallowed by
    // leading-zero suppression when everything to its left was swallowed.
    function automatic logic zero_or_blank(input logic [3:0] code);
        return (code == 4'd0) || (code >= 4'd11);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Purpose : datapath-to-display bundle: digit load side plus the board pin side.
// Latency : n/a (wires only).
// Backpressure: none; load is a fire-and-forget strobe, pending reports the unread value.
// Ports   : master = calculator/bench side, slave = seg7_scan_driver.
interface seg7_scan_driver_if;
    logic       load;
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic [3:0] dp_in;
    logic       lz_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pending;

    modport master (
        output load, d3, d2, d1, d0, dp_in, lz_en,
        input  an, seg, dp, pending
    );

    modport slave (
        input  load, d3, d2, d1, d0, dp_in, lz_en,
        output an, seg, dp, pending
    );
endinterface

// File: rtl/seg7_glyph.sv
// Purpose : 4-bit digit code to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Latency : combinational.
// Backpressure: none.
// Ports   : code in (4), seg out (7); codes 11..15 render blank, 10 renders minus.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = GLYPH_BLANK;
        case (code)
            4'd0:       seg = GLYPH_0;
            4'd1:       seg = GLYPH_1;
            4'd2:       seg = GLYPH_2;
            4'd3:       seg = GLYPH_3;
            4'd4:       seg = GLYPH_4;
            4'd5:       seg = GLYPH_5;
            4'd6:       seg = GLYPH_6;
            4'd7:       seg = GLYPH_7;
            4'd8:       seg = GLYPH_8;
            4'd9:       seg = GLYPH_9;
            CODE_MINUS: seg = GLYPH_MINUS;
            default:    seg = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Purpose : 4-digit common-anode scan driver with tear-free shadow frame and guard slot.
// Latency : outputs registered, 1 cycle behind tick/idx/shadow; load shown within 2..4*TICK_DIV+1 cycles.
// Backpressure: none; a newer load overwrites an uncommitted one, pending flags the waiting value.
// Ports   : clk, reset (sync, active-high), bus (slave): load/d3..d0/dp_in/lz_en in, an/seg/dp/pending out.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic             clk,
    input  logic             reset,
    seg7_scan_driver_if.slave bus
);

    localparam int             TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);

    frame_t          pend_q;
    frame_t          shad_q;
    frame_t          in_frame;
    logic            pending_q;
    logic [TW-1:0]   tick_q;
    logic [1:0]      idx_q;
    logic [3:0]      an_q;
    logic [6:0]      seg_q;
    logic            dp_q;

    logic            tick_end;
    logic            wrap;
    logic [3:0]      sup;
    logic [3:0]      cur_code;
    logic            cur_dp;
    logic [6:0]      cur_seg;

    assign in_frame.dig = {bus.d3, bus.d2, bus.d1, bus.d0};
    assign in_frame.dpm = bus.dp_in;

    assign tick_end = (tick_q == TICK_LAST);
    // Commit only at the end of the last slot so a frame is never torn.
    assign wrap     = tick_end && (idx_q == 2'd3);

    // Suppression is evaluated against the live lz_en and the shadow
    // frame; each digit can only be swallowed if every digit to its left was.
    always_comb begin
        sup    = '0;
        sup[3] = bus.lz_en && (shad_q.dig[3] == 4'd0);
        sup[2] = bus.lz_en && zero_or_blank(shad_q.dig[3]) && zero_or_blank(shad_q.dig[2]);
        sup[1] = sup[2] && zero_or_blank(shad_q.dig[1]);
    end

    assign cur_code = sup[idx_q] ? CODE_BLANK : shad_q.dig[idx_q];
    assign cur_dp   = shad_q.dpm[idx_q] && !sup[idx_q];

    seg7_glyph u_glyph (
        .code (cur_code),
        .seg  (cur_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q    <= '0;
            idx_q     <= 2'd0;
            pending_q <= 1'b0;
            pend_q    <= '0;
            shad_q    <= '{dig: {4{CODE_BLANK}}, dpm: 4'b0000};
            an_q      <= ANODES_OFF;
            seg_q     <= GLYPH_BLANK;
            dp_q      <= 1'b1;
        end else begin
            if (tick_end) begin
                tick_q <= '0;
                idx_q  <= idx_q + 2'd1;
            end else begin
                tick_q <= tick_q + TW'(1);
            end

            // A load coinciding with the wrap bypasses pend and goes
            // straight to the shadow, so pending never rises for it.
            if (wrap) begin
                if (bus.load) begin
                    shad_q <= in_frame;
                    pend_q <= in_frame;
                end else if (pending_q) begin
                    shad_q <= pend_q;
                end
                pending_q <= 1'b0;
            end else if (bus.load) begin
                pend_q    <= in_frame;
                pending_q <= 1'b1;
            end

            // First cycle of each slot is a dark guard to stop ghosting
            // between neighbouring digits.
            if (tick_q == '0) begin
                an_q  <= ANODES_OFF;
                seg_q <= GLYPH_BLANK;
                dp_q  <= 1'b1;
            end else begin
                an_q  <= ~(4'b0001 << idx_q);
                seg_q <= cur_seg;
                dp_q  <= ~cur_dp;
            end
        end
    end

    assign bus.an      = an_q;
    assign bus.seg     = seg_q;
    assign bus.dp      = dp_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Purpose : randomized + directed check of seg7_scan_driver against a frame-level reference model.
// Latency : model predicts registered outputs one cycle after the state they reflect.
// Backpressure: n/a.
module tb_seg7_scan_driver;

    localparam int T = 4;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(.TICK_DIV(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         m_cyc;          // cycles since reset release
    logic [3:0] m_pd [4];
    logic [3:0] m_pdp;
    logic [3:0] m_sd [4];
    logic [3:0] m_sdp;
    bit         m_pnd;

    function automatic logic [6:0] m_glyph(input logic [3:0] c);
        case (c)
            4'd0:  return 7'b1000000;
            4'd1:  return 7'b1111001;
            4'd2:  return 7'b0100100;
            4'd3:  return 7'b0110000;
            4'd4:  return 7'b0011001;
            4'd5:  return 7'b0010010;
            4'd6:  return 7'b0000010;
            4'd7:  return 7'b1111000;
            4'd8:  return 7'b0000000;
            4'd9:  return 7'b0010000;
            4'd10: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic m_reset();
        m_cyc = 0;
        m_pnd = 0;
        m_pdp = 4'b0;
        m_sdp = 4'b0;
        for (int i = 0; i < 4; i++) begin
            m_pd[i] = 4'd0;
            m_sd[i] = 4'd15;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, obs, exp);
        end
    endtask

    // Predict the post-edge outputs from pre-edge model state and inputs,
    // advance one clock, then compare.
    task automatic step();
        logic [3:0] di [4];
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       chk_sd;
        int         tk;
        int         ix;
        bit         run;
        bit         sup [4];

        di[3] = bus.d3; di[2] = bus.d2; di[1] = bus.d1; di[0] = bus.d0;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        chk_sd = 1'b0;
        if (reset) begin
            m_reset();
            chk_sd = 1'b1;
        end else begin
            tk = m_cyc % T;
            ix = (m_cyc / T) % 4;
            run = 1;
            sup[0] = 0;
            for (int i = 3; i >= 1; i--) begin
                run = run && ((m_sd[i] == 0) || (m_sd[i] >= 11));
                sup[i] = bus.lz_en && ((i == 3) ? (m_sd[i] == 0) : run);
            end
            if (tk != 0) begin
                chk_sd   = 1'b1;
                e_an[ix] = 1'b0;
                e_seg    = m_glyph(sup[ix] ? 4'd15 : m_sd[ix]);
                e_dp     = !(m_sdp[ix] && !sup[ix]);
            end
            if (tk == T - 1 && ix == 3) begin
                if (bus.load) begin
                    for (int i = 0; i < 4; i++) m_sd[i] = di[i];
                    m_sdp = bus.dp_in;
                end else if (m_pnd) begin
                    for (int i = 0; i < 4; i++) m_sd[i] = m_pd[i];
                    m_sdp = m_pdp;
                end
                m_pnd = 0;
            end else if (bus.load) begin
                for (int i = 0; i < 4; i++) m_pd[i] = di[i];
                m_pdp = bus.dp_in;
                m_pnd = 1;
            end
            m_cyc++;
        end

        @(posedge clk);
        #1;
        chk("an", 32'(bus.an), 32'(e_an));
        chk("pending", 32'(bus.pending), 32'(m_pnd));
        if (chk_sd) begin
            chk("seg", 32'(bus.seg), 32'(e_seg));
            chk("dp", 32'(bus.dp), 32'(e_dp));
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [3:0] a3, input logic [3:0] a2,
                           input logic [3:0] a1, input logic [3:0] a0,
                           input logic [3:0] dpi);
        bus.d3 = a3; bus.d2 = a2; bus.d1 = a1; bus.d0 = a0;
        bus.dp_in = dpi;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
    endtask

    // Advance until the model sits at the given position in the 4*T frame
    // (the next edge is the one taken from that position).
    task automatic goto_phase(input int ph);
        for (int i = 0; i < 4 * T && (m_cyc % (4 * T)) != ph; i++) step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.load    = 1'b0;
        bus.d3 = 4'd0; bus.d2 = 4'd0; bus.d1 = 4'd0; bus.d0 = 4'd0;
        bus.dp_in   = 4'b0;
        bus.lz_en   = 1'b0;
        m_reset();

        run_cycles(3);
        reset = 1'b0;

        // Idle frames: blank digits, guard cycles dark.
        run_cycles(2 * 4 * T);

        // Basic load, digit order and slot mapping.
        goto_phase(5);
        do_load(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
        run_cycles(2 * 4 * T);

        // Two loads in one frame: last one wins.
        goto_phase(1);
        do_load(4'd5, 4'd5, 4'd5, 4'd5, 4'b0000);
        run_cycles(3);
        do_load(4'd9, 4'd9, 4'd9, 4'd9, 4'b1010);
        run_cycles(2 * 4 * T);

        // Leading-zero suppression with minus sign, then disabled.
        bus.lz_en = 1'b1;
        do_load(4'd0, 4'd0, 4'd10, 4'd7, 4'b1111);
        run_cycles(2 * 4 * T);
        bus.lz_en = 1'b0;
        run_cycles(4 * T);

        // Load exactly on the wrap cycle.
        goto_phase(4 * T - 1);
        do_load(4'd8, 4'd6, 4'd4, 4'd2, 4'b0001);
        run_cycles(2 * 4 * T);

        // Reset during slot 2 with a load pending.
        goto_phase(1);
        do_load(4'd3, 4'd3, 4'd3, 4'd3, 4'b1111);
        goto_phase(2 * T + 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run_cycles(2 * 4 * T);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bus.load = ($urandom_range(0, 9) == 0);
            if (bus.load) begin
                bus.d3    = 4'($urandom_range(0, 15));
                bus.d2    = 4'($urandom_range(0, 15));
                bus.d1    = 4'($urandom_range(0, 15));
                bus.d0    = 4'($urandom_range(0, 15));
                bus.dp_in = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 49) == 0) bus.lz_en = ~bus.lz_en;
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        bus.load = 1'b0;
        reset    = 1'b0;
        run_cycles(4 * T);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a 4-digit, common-anode seven-segment display. It consumes the BCD digit pairs produced by the binary-to-BCD stage, holding operand and result digits. It latches them through a tear-free shadow register and scans one digit at a time with an anti-ghosting blank slot. It sits between the calculator datapath and the board display pins.

## Interface
- `TICK_DIV`, default 100000: clock cycles per digit slot; legal range 2..2^20. Use 4 in simulation.
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `load`  in  1  capture strobe for `d3..d0` and `dp_in`
- `d3`, `d2`, `d1`, `d0`  in  4 each  digit codes; `d3` is leftmost.
- `dp_in`  in  4  decimal-point request per digit; bit i maps to digit i.
- `lz_en`  in  1  leading-zero suppression enable; live, not latched.
- `an`  out  4  anode enables, active-low; bit i maps to digit i.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low
- `dp`  out  1  decimal point, active-low
- `pending`  out  1  a loaded value is waiting for commit.

## Operation
- Glyph map for `seg`:
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001
  - 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000
  - 10→0111111 (minus sign)
  - 11–15→1111111 (blank)
- Registers:
  - `pend[3:0]` digits plus pending dp mask
  - `pending` flag
  - `shad[3:0]` displayed digits plus displayed dp mask
  - `tick` counter, range 0..TICK_DIV-1
  - `idx` slot index, 2 bits
- Load: `load`=1 copies the inputs into `pend` and sets `pending`=1. A later load overwrites the earlier one (last wins).
- Commit: the wrap event is `tick`==TICK_DIV-1 and `idx`==3. On that cycle, if `pending`=1, `shad` takes `pend` and `pending` clears.
- Simultaneous `load` and wrap: the current inputs go straight into `shad`, and `pending` ends at 0.
- Scan: `tick` increments every cycle. At TICK_DIV-1 it returns to 0 and `idx` increments modulo 4, giving order 0,1,2,3,0.
- Leading-zero suppression, when `lz_en`=1:
  - `shad[3]` is shown blank if it is 0.
  - `shad[2]` is shown blank if it and all digits to its left are 0 or blank (codes 11–15).
  - Same rule for `shad[1]`.
  - `shad[0]` is never suppressed.
  - A suppressed digit also forces its dp off.
- Output stage, registered:
  - While `tick`==0, `an`=1111 (guard slot).
  - Otherwise `an` has only bit `idx` low, `seg` = glyph(display digit `idx`), and `dp` = ~dp(`idx`).
- Reset values:
  - `tick`=0, `idx`=0, `pending`=0, `pend`=0
  - `shad` digits all 15, dp mask 0
  - `an`=1111, `seg`=1111111, `dp`=1

## Timing
- Outputs are registered with one-cycle latency: outputs in cycle n+1 reflect `tick`/`idx`/`shad` in cycle n.
- `pending` is visible the cycle after `load`.
- Each slot is TICK_DIV cycles: 1 guard cycle plus TICK_DIV-1 lit cycles. Full frame is 4·TICK_DIV cycles.
- Worst-case load-to-display latency is 4·TICK_DIV+1 cycles. Minimum is 2 cycles (load on the wrap cycle).
- `lz_en` changes take effect on the next output register update; no frame alignment.
- Reset mid-frame returns to slot 0 with `tick`=0 on the next edge. Any pending load is discarded.
- `reset` has priority over `load` in the same cycle.

## Structure
- Shared package `seg7_pkg`:
  - glyph constants GLYPH_0..GLYPH_9, GLYPH_MINUS, GLYPH_BLANK
  - code constants CODE_MINUS=10, CODE_BLANK=15
  - ANODES_OFF=4'b1111
- One combinational sub-module `seg7_glyph`: 4-bit code in, 7-bit active-low pattern out. It is shared by this block and any future status display.
- The counter, commit logic, suppression logic and output registers stay in `seg7_scan_driver`.

## Test plan
All scenarios use TICK_DIV=4.
- Reset released, no load:
  - `an`=1111 on every guard cycle.
  - Lit cycles show `seg`=1111111 on every digit.
  - `pending`=0.
- Load d3..d0=1,2,3,4 at cycle 5, `lz_en`=0:
  - `pending`=1 until the next wrap.
  - Following frame shows slot 0 `seg`=0011001 with `an`=1110, slot 3 `seg`=1111001 with `an`=0111.
  - `pending`=0 afterward.
- Two loads (5,5,5,5 then 9,9,9,9) within one frame → only 0010000 (digit 9) is ever displayed; 5 never appears.
- Load 0,0,10,7, `lz_en`=1:
  - d3 and d2 blank (1111111).
  - d1 shows minus (0111111); d0 shows 1111000 (digit 7).
  - With `lz_en`=0, d3 and d2 show 1000000 (digit 0).
- Load on the exact wrap cycle with `dp_in`=0001 → next frame shows the new digits, `dp`=0 on slot 0 only, `pending` never asserts.
- Assert `reset` during slot 2 with a load pending:
  - Next cycle `an`=1111, `seg`=1111111, `pending`=0.
  - Scan restarts at slot 0; the display stays blank.
